serial_tx_queue: RTL and testbench



---
 rtl/serial_pkg.sv | 12 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/serial_tx_queue.sv | 144 ++++++++++++++
 tb/tb_serial_tx_queue.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmit queue.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  function automatic int frame_bits(input int data_w, input int stop_bits, input bit parity);
    return 1 + data_w + stop_bits + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered occupancy; read data is the head entry, valid whenever not empty.
// Zero-latency head read; push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/serial_tx_queue.sv
// Queued serial transmitter: LSB-first start/data/stop frames, OVERSAMPLE clocks per bit; SERIAL_TX_PARITY_EN adds an even-parity bit.
// Latency: a word pushed into an empty, idle queue is popped on the next edge and its start bit follows immediately.
// Backpressure: wr_ready low while the FIFO is full; a write while full is dropped and sets sticky overflow.
module serial_tx_queue
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       tx,
  output logic                       busy,
  output logic                       frame_done,
  output logic [4:0]                 bic,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       clr_overflow
);

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int              FRAME_BITS = frame_bits(DATA_W, STOP_BITS, PAR_EN);
  localparam int              CW         = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [4:0]      LAST_DATA  = 5'(DATA_W);
  localparam logic [4:0]      LAST_BIC   = 5'(FRAME_BITS - 1);

  tx_state_t          state;
  logic [CW-1:0]      cnt;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               bit_end;
  logic               frame_end;

  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && wr_ready;
  assign bit_end    = (cnt == CNT_LAST);
  assign frame_end  = (state == STOP) && bit_end && (bic == LAST_BIC);
  // Popping on the last stop cycle lets the next start bit follow with no idle gap.
  assign pop        = !fifo_empty && ((state == IDLE) || frame_end);
  assign busy       = (state != IDLE);
  assign frame_done = frame_end;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bic   <= '0;
      shreg <= '0;
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (pop) begin
          state <= START;
          bic   <= '0;
          shreg <= fifo_dout;
        end
        START: if (bit_end) begin
          state <= DATA;
          bic   <= bic + 5'd1;
        end
        DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          bic   <= bic + 5'd1;
`ifdef SERIAL_TX_PARITY_EN
          if (bic == LAST_DATA) state <= PAR;
`else
          if (bic == LAST_DATA) state <= STOP;
`endif
        end
        PAR: if (bit_end) begin
          state <= STOP;
          bic   <= bic + 5'd1;
        end
        STOP: if (frame_end) begin
          bic <= '0;
          if (pop) begin
            state <= START;
            shreg <= fifo_dout;
          end else begin
            state <= IDLE;
          end
        end else if (bit_end) begin
          bic <= bic + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk) begin
    if (reset)    par_bit <= 1'b0;
    else if (pop) par_bit <= ^fifo_dout;
  end
`endif

  // A write while full always sets the flag, even if a clear arrives on the same edge.
  always_ff @(posedge clk) begin
    if (reset)                      overflow <= 1'b0;
    else if (wr_valid && !wr_ready) overflow <= 1'b1;
    else if (clr_overflow)          overflow <= 1'b0;
  end

  always_comb begin
    tx = TX_IDLE_LEVEL;
    case (state)
      START: tx = ~TX_IDLE_LEVEL;
      DATA:  tx = shreg[0];
`ifdef SERIAL_TX_PARITY_EN
      PAR:   tx = par_bit;
`endif
      default: tx = TX_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_queue.sv
// Bench for serial_tx_queue: frame-position reference model checked every cycle, plus a line decoder pinned by literals.
module tb_serial_tx_queue;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4;
  localparam int OS        = 4;
  localparam int STOP_BITS = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P          = 1;
  localparam int FLEN_LIT   = 44;
  localparam int BICMAX_LIT = 10;
`else
  localparam int P          = 0;
  localparam int FLEN_LIT   = 40;
  localparam int BICMAX_LIT = 9;
`endif
  localparam int NBITS = 1 + DATA_W + P + STOP_BITS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic              clr_overflow = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready, tx, busy, frame_done, overflow;
  logic [4:0]        bic;
  logic [2:0]        level;

  always #5 clk = ~clk;

  serial_tx_queue #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .OVERSAMPLE(OS), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .tx(tx), .busy(busy), .frame_done(frame_done),
    .bic(bic), .level(level), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted words and position within the current frame.
  int mq[$];
  bit m_busy = 0;
  int m_pos  = 0;
  int m_word = 0;
  bit m_ovf  = 0;

  // Line observer: decodes the DUT's tx like a receiver would.
  int                fc = 0;
  int                bic_max = 0;
  int                busy_cycles = 0;
  logic              par_seen = 1'b0;
  logic [DATA_W-1:0] rx_cur = '0;
  logic [DATA_W-1:0] rx_log[$];
  int                fd_log[$];
  int                lvl_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic fbit(input int w, input int b);
    logic [DATA_W-1:0] wv;
    wv = DATA_W'(w);
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return wv[b-1];
    if (P == 1 && b == DATA_W + 1) return ^wv;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit rdy;
    bit popnow;
    if (reset) begin
      mq.delete();
      m_busy = 0;
      m_pos  = 0;
      m_ovf  = 0;
    end else begin
      rdy    = (mq.size() != DEPTH);
      popnow = 0;
      if (m_busy) begin
        if (m_pos == NBITS*OS - 1) begin
          m_busy = 0;
          popnow = (mq.size() > 0);
        end else begin
          m_pos++;
        end
      end else begin
        popnow = (mq.size() > 0);
      end
      if (popnow) begin
        m_word = mq.pop_front();
        m_busy = 1;
        m_pos  = 0;
      end
      if (wr_valid && rdy) mq.push_back(int'(wr_data));
      if (wr_valid && !rdy) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
    end
  endtask

  task automatic compare_and_observe();
    logic etx;
    logic efd;
    int   ebic;
    int   c;
    int   b;
    if (m_busy) begin
      ebic = m_pos / OS;
      etx  = fbit(m_word, ebic);
      efd  = (m_pos == NBITS*OS - 1);
    end else begin
      ebic = 0;
      etx  = 1'b1;
      efd  = 1'b0;
    end
    check("tx", tx, etx);
    check("busy", busy, m_busy);
    check("frame_done", frame_done, efd);
    check("bic", bic, ebic);
    check("level", level, mq.size());
    check("wr_ready", wr_ready, mq.size() != DEPTH);
    check("overflow", overflow, m_ovf);

    if (busy) begin
      fc++;
      busy_cycles++;
      if (fc == 1) lvl_log.push_back(int'(level));
      if (int'(bic) > bic_max) bic_max = int'(bic);
      c = fc - 1;
      if (c % OS == OS/2) begin
        b = c / OS;
        if (b >= 1 && b <= DATA_W) rx_cur[b-1] = tx;
        if (b == DATA_W + 1) par_seen = tx;
      end
      if (frame_done) begin
        fd_log.push_back(fc);
        rx_log.push_back(rx_cur);
        fc = 0;
      end
    end else begin
      fc = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_and_observe();
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_data  = DATA_W'($urandom);
  endtask

  task automatic drain(input string name, input int maxc);
    int k;
    k = 0;
    while ((busy || level != 0) && k < maxc) begin
      tick();
      k++;
    end
    check(name, (busy || level != 0), 0);
    tick();
    tick();
  endtask

  task automatic expect_word(input string name, input logic [31:0] w);
    logic [31:0] got;
    got = 32'hDEAD_BEEF;
    if (rx_log.size() > 0) got = 32'(rx_log.pop_front());
    check(name, got, w);
  endtask

  task automatic clear_obs();
    rx_log.delete();
    fd_log.delete();
    lvl_log.delete();
    bic_max     = 0;
    busy_cycles = 0;
  endtask

  initial begin
    int n;

    // Reset state
    tick();
    tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_overflow", overflow, 0);
    check("rst_bic", bic, 0);
    reset = 1'b0;
    tick();

    // Single frame 0xA5: first-transaction latency, length, bit order
    clear_obs();
    push(8'hA5);
    check("a5_level_after_push", level, 1);
    check("a5_tx_idle_after_push", tx, 1);
    tick();
    check("a5_start_tx", tx, 0);
    check("a5_start_busy", busy, 1);
    check("a5_level_popped", level, 0);
    drain("a5_timeout", 100);
    check("a5_frames", fd_log.size(), 1);
    check("a5_frame_len", fd_log[0], FLEN_LIT);
    check("a5_busy_cycles", busy_cycles, FLEN_LIT);
    check("a5_bic_max", bic_max, BICMAX_LIT);
`ifdef SERIAL_TX_PARITY_EN
    check("a5_parity", par_seen, 0);
`endif
    expect_word("a5_word", 8'hA5);

    // 0x07: odd number of ones
    clear_obs();
    push(8'h07);
    drain("w07_timeout", 100);
    check("w07_frame_len", fd_log[0], FLEN_LIT);
    check("w07_bic_max", bic_max, BICMAX_LIT);
`ifdef SERIAL_TX_PARITY_EN
    check("w07_parity", par_seen, 1);
`endif
    expect_word("w07_word", 8'h07);

    // Back-to-back frames with no idle gap
    clear_obs();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check("b2b_level_after_pushes", level, 2);
    drain("b2b_timeout", 200);
    check("b2b_frames", fd_log.size(), 3);
    check("b2b_busy_cycles", busy_cycles, 3*FLEN_LIT);
    check("b2b_lvl_count", lvl_log.size(), 3);
    check("b2b_lvl0", lvl_log[0], 1);
    check("b2b_lvl1", lvl_log[1], 1);
    check("b2b_lvl2", lvl_log[2], 0);
    expect_word("b2b_w0", 8'h01);
    expect_word("b2b_w1", 8'h02);
    expect_word("b2b_w2", 8'h03);

    // Overflow: fill while a frame stalls the pop, then write once more
    clear_obs();
    push(8'h10);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    push(8'h14);
    check("ovf_level_full", level, 4);
    check("ovf_wr_ready", wr_ready, 0);
    push(8'hEE);
    check("ovf_set", overflow, 1);
    check("ovf_level_kept", level, 4);
    tick();
    tick();
    check("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    push(8'hEF);
    check("ovf_set_wins", overflow, 1);
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    drain("ovf_timeout", 400);
    expect_word("ovf_w0", 8'h10);
    expect_word("ovf_w1", 8'h11);
    expect_word("ovf_w2", 8'h12);
    expect_word("ovf_w3", 8'h13);
    expect_word("ovf_w4", 8'h14);
    check("ovf_no_dropped_word", rx_log.size(), 0);

    // Push and pop on the same edge at level 2
    clear_obs();
    push(8'h3C);
    push(8'hC3);
    push(8'h5A);
    check("pp_level_before", level, 2);
    n = 0;
    while (!frame_done && n < 60) begin
      tick();
      n++;
    end
    check("pp_wait_frame_done", frame_done, 1);
    push(8'h96);
    check("pp_level_same", level, 2);
    check("pp_next_start", tx, 0);
    drain("pp_timeout", 300);
    expect_word("pp_w0", 8'h3C);
    expect_word("pp_w1", 8'hC3);
    expect_word("pp_w2", 8'h5A);
    expect_word("pp_w3", 8'h96);

    // Reset in the middle of a frame discards it and the queued word
    clear_obs();
    push(8'h55);
    push(8'hAA);
    n = 0;
    while (fc != 15 && n < 60) begin
      tick();
      n++;
    end
    check("mid_wait_cycle15", fc, 15);
    reset = 1'b1;
    tick();
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", level, 0);
    reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 100; i++) tick();
    check("mid_no_frames", fd_log.size(), 0);
    check("mid_no_busy", busy_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
